// File: rtl/key_entry_ctrl_pkg.sv
// Shared definitions for the keyboard key-entry path: PS/2 set-2 scan codes,
// controller state encoding and a small classifier for the control keys.
package key_entry_ctrl_pkg;

  // Digit make codes, index = decimal value
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;

  // Editing keys and the break prefix (the latter is simply ignored here)
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Upper bound on the digits an entry can hold (entry_count is 3 bits wide)
  localparam int N_DIG_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KEY_OTHER = 2'd0,
    KEY_ENTER = 2'd1,
    KEY_BKSP  = 2'd2,
    KEY_ESC   = 2'd3
  } ctrl_key_e;

  // Map a non-digit scan code onto the editing action it requests
  function automatic ctrl_key_e classify_ctrl(input logic [7:0] code);
    case (code)
      SC_ENTER: classify_ctrl = KEY_ENTER;
      SC_BKSP:  classify_ctrl = KEY_BKSP;
      SC_ESC:   classify_ctrl = KEY_ESC;
      default:  classify_ctrl = KEY_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/key_entry_ctrl_if.sv
// Key-code FIFO read port: the FIFO presents its head code and an empty flag,
// the consumer returns a one-cycle pop strobe.
interface key_entry_ctrl_if;

  logic       kb_buf_empty;
  logic [7:0] codigo_tecla;
  logic       leer_codigo_tecla;

  // Consumer side (the entry controller)
  modport master (
    input  kb_buf_empty,
    input  codigo_tecla,
    output leer_codigo_tecla
  );

  // FIFO side
  modport slave (
    output kb_buf_empty,
    output codigo_tecla,
    input  leer_codigo_tecla
  );

endinterface

// File: rtl/key_entry_ctrl_scan_digit_dec.sv
// Combinational scan-code to decimal-digit translator.
module scan_digit_dec
  import key_entry_ctrl_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit,
  output logic [3:0] digit
);

  // Look up the digit value of a make code; anything else is not a digit
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    is_digit = 1'b1;
    digit    = 4'd0;
    case (code)
      SC_0:    digit = 4'd0;
      SC_1:    digit = 4'd1;
      SC_2:    digit = 4'd2;
      SC_3:    digit = 4'd3;
      SC_4:    digit = 4'd4;
      SC_5:    digit = 4'd5;
      SC_6:    digit = 4'd6;
      SC_7:    digit = 4'd7;
      SC_8:    digit = 4'd8;
      SC_9:    digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Numeric key-entry controller: pops scan codes from the keyboard FIFO, builds
// an N_DIG-digit BCD entry with backspace/escape editing, and commits it on
// Enter. Each key costs two cycles (pop + decode); a commit adds one more.
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int N_DIG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  key_entry_ctrl_if.master     kb,
  output logic [4*N_DIG-1:0]   entry_bcd,
  output logic [2:0]           entry_count,
  output logic [4*N_DIG-1:0]   value_bcd,
  output logic                 value_valid,
  output logic                 err_tick
);

  localparam int         W       = 4 * N_DIG;
  localparam logic [2:0] CNT_MAX = 3'(N_DIG);

  state_e         state_q, state_d;
  logic [7:0]     code_q, code_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   value_q, value_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           pop;

  logic           dec_is_digit;
  logic [3:0]     dec_digit;

  // The latched code is decoded in the cycle after it was popped
  scan_digit_dec u_scan_digit_dec (
    .code     (code_q),
    .is_digit (dec_is_digit),
    .digit    (dec_digit)
  );

  // Next-state, entry editing and strobe generation
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        // Pop and latch in the same cycle so queued keys stream with no gap
        if (!kb.kb_buf_empty) begin
          pop     = 1'b1;
          code_d  = kb.codigo_tecla;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = IDLE;
        if (dec_is_digit) begin
          if (cnt_q < CNT_MAX) begin
            entry_d = (entry_q << 4) | W'(dec_digit);
            cnt_d   = cnt_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          case (classify_ctrl(code_q))
            KEY_BKSP: begin
              if (cnt_q != 3'd0) begin
                entry_d = entry_q >> 4;
                cnt_d   = cnt_q - 3'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            KEY_ESC: begin
              entry_d = '0;
              cnt_d   = 3'd0;
            end
            KEY_ENTER: begin
              if (cnt_q != 3'd0) begin
                state_d = COMMIT;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;  // break prefix and unused keys are dropped silently
          endcase
        end
      end

      COMMIT: begin
        value_d = entry_q;
        valid_d = 1'b1;
        entry_d = '0;
        cnt_d   = 3'd0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any pending action
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 8'h00;
      entry_q <= '0;
      cnt_q   <= 3'd0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // The pop strobe is combinational so it lines up with the latch cycle;
  // it is masked during reset so the FIFO is not drained while held in reset.
  assign kb.leer_codigo_tecla = pop & ~rst;

  assign entry_bcd   = entry_q;
  assign entry_count = cnt_q;
  assign value_bcd   = value_q;
  assign value_valid = valid_q;
  assign err_tick    = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: directed scenarios plus randomized
// key streams checked against a digit-list reference model.
module tb_key_entry_ctrl;

  localparam int N_DIG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_entry_ctrl_if kb_bus ();

  logic [4*N_DIG-1:0] entry_bcd, value_bcd;
  logic [2:0]         entry_count;
  logic               value_valid, err_tick;

  key_entry_ctrl #(.N_DIG(N_DIG)) dut (
    .clk         (clk),
    .rst         (rst),
    .kb          (kb_bus),
    .entry_bcd   (entry_bcd),
    .entry_count (entry_count),
    .value_bcd   (value_bcd),
    .value_valid (value_valid),
    .err_tick    (err_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo[$];
  int         pops, errs, valids;
  logic       prev_pop = 1'b0;

  // Reference model: the entered digits in typing order plus the last commit
  int m_dig[$];
  int m_value = 0;

  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int digit_of(input logic [7:0] c);
    digit_of = -1;
    for (int i = 0; i < 10; i++) if (dig_codes[i] == c) digit_of = i;
  endfunction

  function automatic int model_bcd();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return v;
  endfunction

  task automatic model_key(input logic [7:0] c, output int e_err, output int e_commit);
    int d = digit_of(c);
    e_err = 0;
    e_commit = 0;
    if (d >= 0) begin
      if (m_dig.size() < N_DIG) m_dig.push_back(d);
      else e_err = 1;
    end else if (c == 8'h66) begin
      if (m_dig.size() > 0) void'(m_dig.pop_back());
      else e_err = 1;
    end else if (c == 8'h76) begin
      m_dig.delete();
    end else if (c == 8'h5A) begin
      if (m_dig.size() > 0) begin
        m_value = model_bcd();
        m_dig.delete();
        e_commit = 1;
      end else e_err = 1;
    end
  endtask

  task automatic drive_fifo();
    kb_bus.kb_buf_empty = (fifo.size() == 0);
    kb_bus.codigo_tecla = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // One clock: sample the pop strobe mid-cycle, advance, then apply the pop
  // to the FIFO model and accumulate output pulses.
  task automatic tick();
    logic p, e;
    #1;
    p = kb_bus.leer_codigo_tecla;
    e = kb_bus.kb_buf_empty;
    n_tests++;
    if (p === 1'b1 && (e === 1'b1 || prev_pop === 1'b1)) begin
      n_fail++;
      $display("FAIL pop_protocol: leer=%b empty=%b prev_leer=%b, required no pop when empty or twice in a row", p, e, prev_pop);
    end
    prev_pop = p;
    @(posedge clk);
    #1;
    if (p === 1'b1) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      pops++;
    end
    drive_fifo();
    if (err_tick === 1'b1) errs++;
    if (value_valid === 1'b1) valids++;
    n_tests++;
    if (err_tick === 1'b1 && value_valid === 1'b1) begin
      n_fail++;
      $display("FAIL err_valid_overlap: err_tick=1 value_valid=1, required never both high");
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    fifo.delete();
    drive_fifo();
    tick();
    tick();
    rst = 1'b0;
    m_dig.delete();
    m_value = 0;
    pops = 0; errs = 0; valids = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo.delete();
    drive_fifo();
    tick();
    tick();
    n_tests++;
    if ({entry_bcd, entry_count, value_bcd, value_valid, err_tick, kb_bus.leer_codigo_tecla} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: entry=%h cnt=%0d value=%h vv=%b err=%b leer=%b, required all 0",
               entry_bcd, entry_count, value_bcd, value_valid, err_tick, kb_bus.leer_codigo_tecla);
    end
    n_tests++;
    if (dut.code_q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_code_reg: got %h, required 00", dut.code_q);
    end
    rst = 1'b0;
    m_dig.delete();
    m_value = 0;
  endtask

  task automatic test_commit();
    logic [11:0] exp;
    reset_dut();
    fifo = {8'h16, 8'h1E, 8'h26, 8'h5A};
    drive_fifo();
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 2 || t == 4 || t == 6) begin
        exp = (t == 2) ? 12'h001 : (t == 4) ? 12'h012 : 12'h123;
        n_tests++;
        if (entry_bcd !== exp) begin
          n_fail++;
          $display("FAIL commit_entry_t%0d: got %h, required %h", t, entry_bcd, exp);
        end
      end
      if (t == 9) begin
        n_tests++;
        if (!(value_valid === 1'b1 && value_bcd === 12'h123 && entry_bcd === 12'h000 && entry_count === 3'd0)) begin
          n_fail++;
          $display("FAIL commit_value: vv=%b value=%h entry=%h cnt=%0d, required vv=1 value=123 entry=000 cnt=0",
                   value_valid, value_bcd, entry_bcd, entry_count);
        end
      end
    end
    n_tests++;
    if (valids != 1 || errs != 0) begin
      n_fail++;
      $display("FAIL commit_pulses: value_valid pulses=%0d err pulses=%0d, required 1 and 0", valids, errs);
    end
    n_tests++;
    if (value_bcd !== 12'h123) begin
      n_fail++;
      $display("FAIL commit_hold: value=%h, required 123 held", value_bcd);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    fifo = {8'h16, 8'h1E, 8'h26, 8'h25};
    drive_fifo();
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 8) begin
        n_tests++;
        if (err_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL overflow_err: err_tick=%b, required 1", err_tick);
        end
      end
    end
    n_tests++;
    if (entry_bcd !== 12'h123 || entry_count !== 3'd3 || errs != 1) begin
      n_fail++;
      $display("FAIL overflow_entry: entry=%h cnt=%0d errs=%0d, required 123 3 1", entry_bcd, entry_count, errs);
    end
  endtask

  task automatic test_backspace();
    reset_dut();
    fifo = {8'h16, 8'h1E, 8'h66, 8'h66, 8'h66};
    drive_fifo();
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 4 || t == 6 || t == 8) begin
        logic [11:0] exp;
        logic [2:0]  exp_c;
        exp   = (t == 4) ? 12'h012 : (t == 6) ? 12'h001 : 12'h000;
        exp_c = (t == 4) ? 3'd2 : (t == 6) ? 3'd1 : 3'd0;
        n_tests++;
        if (entry_bcd !== exp || entry_count !== exp_c) begin
          n_fail++;
          $display("FAIL bksp_t%0d: entry=%h cnt=%0d, required %h %0d", t, entry_bcd, entry_count, exp, exp_c);
        end
      end
      if (t == 10) begin
        n_tests++;
        if (err_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL bksp_empty_err: err_tick=%b, required 1", err_tick);
        end
      end
    end
    n_tests++;
    if (errs != 1) begin
      n_fail++;
      $display("FAIL bksp_err_count: got %0d, required 1", errs);
    end
  endtask

  task automatic test_enter_empty_escape();
    reset_dut();
    fifo = {8'h5A};
    drive_fifo();
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 2) begin
        n_tests++;
        if (err_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL enter_empty_err: err_tick=%b, required 1", err_tick);
        end
      end
    end
    n_tests++;
    if (valids != 0 || errs != 1) begin
      n_fail++;
      $display("FAIL enter_empty_pulses: valid=%0d err=%0d, required 0 and 1", valids, errs);
    end
    errs = 0;
    fifo = {8'h45, 8'h16, 8'h76};
    drive_fifo();
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 4) begin
        n_tests++;
        if (entry_bcd !== 12'h001 || entry_count !== 3'd2) begin
          n_fail++;
          $display("FAIL esc_pre: entry=%h cnt=%0d, required 001 2", entry_bcd, entry_count);
        end
      end
    end
    n_tests++;
    if (entry_bcd !== 12'h000 || entry_count !== 3'd0 || errs != 0) begin
      n_fail++;
      $display("FAIL esc_clear: entry=%h cnt=%0d errs=%0d, required 000 0 0", entry_bcd, entry_count, errs);
    end
  endtask

  task automatic test_throughput();
    reset_dut();
    for (int t = 0; t < 20; t++) tick();
    n_tests++;
    if (pops != 0) begin
      n_fail++;
      $display("FAIL idle_no_pop: pops=%0d, required 0", pops);
    end
    fifo = {8'h16, 8'h1E, 8'h66, 8'h76};
    drive_fifo();
    pops = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 6) begin
        n_tests++;
        if (pops != 3) begin
          n_fail++;
          $display("FAIL throughput_mid: pops after 6 cycles=%0d, required 3", pops);
        end
      end
    end
    n_tests++;
    if (pops != 4 || fifo.size() != 0) begin
      n_fail++;
      $display("FAIL throughput_8: pops=%0d left=%0d, required 4 and 0", pops, fifo.size());
    end
    n_tests++;
    if (entry_bcd !== 12'h000 || entry_count !== 3'd0) begin
      n_fail++;
      $display("FAIL throughput_entry: entry=%h cnt=%0d, required 000 0", entry_bcd, entry_count);
    end
  endtask

  task automatic test_reset_in_commit();
    reset_dut();
    fifo = {8'h16, 8'h5A};
    drive_fifo();
    for (int t = 1; t <= 4; t++) tick();   // now in the COMMIT cycle
    rst = 1'b1;
    tick();
    n_tests++;
    if ({entry_bcd, entry_count, value_bcd, value_valid, err_tick, kb_bus.leer_codigo_tecla} !== '0) begin
      n_fail++;
      $display("FAIL rst_commit_outputs: entry=%h cnt=%0d value=%h vv=%b err=%b, required all 0",
               entry_bcd, entry_count, value_bcd, value_valid, err_tick);
    end
    rst = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    n_tests++;
    if (valids != 0 || value_bcd !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_commit_abort: valid pulses=%0d value=%h, required 0 and 000", valids, value_bcd);
    end
    m_dig.delete();
    m_value = 0;
  endtask

  function automatic logic [7:0] rand_key();
    int r = $urandom_range(0, 15);
    if (r < 10) return dig_codes[r];
    case (r)
      10:      return 8'h66;
      11:      return 8'h76;
      12, 13:  return 8'h5A;
      14:      return 8'hF0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic check_model(input string tag, input int e_err, input int e_commit);
    n_tests++;
    if (entry_bcd !== 12'(model_bcd()) || entry_count !== 3'(m_dig.size()) ||
        value_bcd !== 12'(m_value) || errs != e_err || valids != e_commit) begin
      n_fail++;
      $display("FAIL %s: entry=%h cnt=%0d value=%h errs=%0d valids=%0d, required %h %0d %h %0d %0d",
               tag, entry_bcd, entry_count, value_bcd, errs, valids,
               12'(model_bcd()), m_dig.size(), 12'(m_value), e_err, e_commit);
    end
  endtask

  task automatic test_random_single();
    logic [7:0] c;
    int e_err, e_commit;
    reset_dut();
    for (int k = 0; k < 150; k++) begin
      c = rand_key();
      model_key(c, e_err, e_commit);
      errs = 0; valids = 0; pops = 0;
      fifo.push_back(c);
      drive_fifo();
      for (int t = 0; t < 4; t++) tick();
      check_model($sformatf("rand_key_%0d_%h", k, c), e_err, e_commit);
      n_tests++;
      if (pops != 1) begin
        n_fail++;
        $display("FAIL rand_pop_%0d: pops=%0d, required 1", k, pops);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    int e_err, e_commit, tot_err, tot_commit, n;
    reset_dut();
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(2, 6);
      tot_err = 0; tot_commit = 0;
      errs = 0; valids = 0;
      for (int k = 0; k < n; k++) begin
        c = rand_key();
        model_key(c, e_err, e_commit);
        tot_err += e_err;
        tot_commit += e_commit;
        fifo.push_back(c);
      end
      drive_fifo();
      for (int t = 0; t < 3 * n + 3; t++) tick();
      check_model($sformatf("burst_%0d", b), tot_err, tot_commit);
    end
  endtask

  initial begin
    fifo.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    test_reset();
    test_commit();
    test_overflow();
    test_backspace();
    test_enter_empty_escape();
    test_throughput();
    test_reset_in_commit();
    test_random_single();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_entry_ctrl.md
KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

Interface
REQ-001 The block SHALL have parameter N_DIG, default 3, giving the maximum number of decimal digits per entry (range 1..4).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port kb_buf_empty, input, 1, high when the key-code FIFO is empty.
REQ-005 The block SHALL have port codigo_tecla, input, 8, the PS/2 set-2 scan code at the FIFO head, valid whenever kb_buf_empty is low.
REQ-006 The block SHALL have port leer_codigo_tecla, output, 1, a one-cycle pop strobe to the FIFO.
REQ-007 The block SHALL have port entry_bcd, output, 4*N_DIG, the live BCD entry, least significant digit in bits [3:0].
REQ-008 The block SHALL have port entry_count, output, 3, the number of digits currently entered (0..N_DIG).
REQ-009 The block SHALL have port value_bcd, output, 4*N_DIG, the last committed entry, held until the next commit.
REQ-010 The block SHALL have port value_valid, output, 1, a one-cycle pulse when value_bcd updates.
REQ-011 The block SHALL have port err_tick, output, 1, a one-cycle pulse on a rejected key.

Function
REQ-012 The FSM SHALL have the states IDLE, DECODE and COMMIT.
REQ-013 In IDLE with kb_buf_empty low, the block SHALL latch codigo_tecla into code_reg, assert leer_codigo_tecla for that same cycle, and move to DECODE.
REQ-014 leer_codigo_tecla SHALL never be asserted while kb_buf_empty is high, nor in two consecutive cycles.
REQ-015 In DECODE, a digit code (0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9) with entry_count<N_DIG SHALL shift entry_bcd left one nibble, insert the digit at [3:0], increment entry_count, and return to IDLE.
REQ-016 A digit with entry_count==N_DIG SHALL leave the entry unchanged, pulse err_tick, and return to IDLE.
REQ-017 Backspace (0x66) with entry_count>0 SHALL shift entry_bcd right one nibble, zero-fill the top nibble, decrement entry_count, and return to IDLE; with entry_count==0 it SHALL pulse err_tick.
REQ-018 Escape (0x76) SHALL clear entry_bcd and entry_count to 0 without err_tick and return to IDLE.
REQ-019 Enter (0x5A) with entry_count>0 SHALL go to COMMIT; with entry_count==0 it SHALL pulse err_tick and return to IDLE.
REQ-020 Any other code SHALL be discarded silently (no err_tick) and the FSM SHALL return to IDLE.
REQ-021 In COMMIT, the block SHALL copy entry_bcd to value_bcd, pulse value_valid for exactly one cycle, clear the entry, and return to IDLE.
REQ-022 Throughput SHALL be one key per 2 cycles (3 for a successful Enter); keys already in the FIFO SHALL be consumed back-to-back with no extra idle cycle.
REQ-023 err_tick and value_valid SHALL never be high in the same cycle.

Reset
REQ-024 On rst the block SHALL enter IDLE and drive leer_codigo_tecla=0, entry_bcd=0, entry_count=0, value_bcd=0, value_valid=0, err_tick=0, code_reg=0.
REQ-025 A reset asserted in DECODE or COMMIT SHALL abort the action (no value_valid, no entry change) and SHALL take priority over all other inputs.

Structure
REQ-026 The scan-code constants (digit codes, 0x5A, 0x66, 0x76, break code 0xF0) and the state encoding SHALL live in a shared package used by the keyboard-capture path.
REQ-027 The scan-code-to-digit translation SHALL be a combinational sub-module scan_digit_dec (8-bit code in; is_digit and 4-bit digit out).

Verification
REQ-028 The bench SHALL check: FIFO holds 0x16,0x1E,0x26,0x5A -> entry_bcd 0x001,0x012,0x123; value_bcd=0x123 with one value_valid pulse; entry cleared.
REQ-029 The bench SHALL check: 0x16,0x1E,0x26,0x25 (N_DIG=3) -> fourth key gives err_tick and entry stays 0x123, count 3.
REQ-030 The bench SHALL check: 0x16,0x1E,0x66,0x66,0x66 -> entry 0x012, then 0x001, then 0x000; the third backspace gives err_tick.
REQ-031 The bench SHALL check: 0x5A on an empty entry gives err_tick and no value_valid; 0x76 after 0x45,0x16 gives entry=0 and count=0.
REQ-032 The bench SHALL check: FIFO empty for 20 cycles -> leer_codigo_tecla stays 0; four queued keys are popped in exactly 8 cycles.
REQ-033 The bench SHALL check: rst asserted in the COMMIT cycle -> no value_valid and all outputs equal 0 on the next cycle.
